fm_input_conditioner: RTL
=========================

// Module: fm_input_conditioner
// PURPOSE
//  Input front end for the two-input fundamental-mode state machine on EGO1.
//  Synchronizes and debounces two raw button/switch inputs, then presents them as x2/x1
//  so that at most one input changes at a time, with a settle gap after each change.
//  Feeds x2/x1 directly to the downstream next-state/output logic.
// PARAMETERS
//  SYNC_STAGES      2          synchronizer flops per input (>=2)
//  DEBOUNCE_CYCLES  1_000_000  consecutive stable cycles required to accept a level (>=1; 10 ms @100 MHz)
//  SETTLE_CYCLES    16         quiet cycles after each accepted output change (>=1)
// PORTS
//  sys_clk_in    in   1  system clock
//  sys_rst_n     in   1  asynchronous reset, active low
//  btn_x2        in   1  raw asynchronous input for x2
//  btn_x1        in   1  raw asynchronous input for x1
//  x2            out  1  conditioned x2 to the state machine
//  x1            out  1  conditioned x1 to the state machine
//  change_pulse  out  1  one-cycle pulse in the cycle x2 or x1 takes a new value
//  busy          out  1  high while in SETTLE
//  dual_chg      out  1  sticky: both debounced levels differed from outputs at once
//  chg_cnt       out  8  accepted-change count (present only with FMIC_CHANGE_CNT_EN)
// BEHAVIOUR
//  - Reset (async assert, sync release): all sync flops, debounced levels, counters, x2, x1,
//    change_pulse, busy, dual_chg, chg_cnt = 0; FSM = IDLE. Reset mid-operation discards any
//    pending second change; inputs already high are re-debounced from zero after release.
//  - Debounce per input: counter clears whenever synchronized value equals debounced level;
//    otherwise increments; at DEBOUNCE_CYCLES the debounced level flips and counter clears.
//    Pulses shorter than DEBOUNCE_CYCLES produce no change.
//  - Latency, FSM idle: raw edge to x change = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
//  - FSM IDLE: compare debounced {d2,d1} with {x2,x1}.
//      one bit differs -> update that output next edge, change_pulse=1, go SETTLE.
//      both differ     -> update x1 only (x1 has priority), set dual_chg, go SETTLE;
//                         x2 is issued from the following IDLE cycle.
//      none            -> stay IDLE.
//  - FSM SETTLE: busy=1 for exactly SETTLE_CYCLES cycles, no output changes, then IDLE.
//    Gap between consecutive output changes is therefore >= SETTLE_CYCLES+1 cycles.
//  - IDLE always uses current debounced levels: a level that reverts during SETTLE is never
//    issued as a stale change.
//  - change_pulse is never high in two consecutive cycles; x2 and x1 never change together.
// CONFIGURATION
//  FMIC_CHANGE_CNT_EN defined: chg_cnt port exists; increments by 1 on every change_pulse,
//    wraps 255->0, reset to 0. Not defined: port and counter absent; all else identical.
// STRUCTURE
//  fmic_pkg: FSM state typedef (IDLE, SETTLE), default parameter constants, counter widths
//    derived with $clog2 of DEBOUNCE_CYCLES / SETTLE_CYCLES.
//  Sub-module fmic_debounce (synchronizer + debounce counter), instantiated once per input;
//  top holds FSM, settle counter, output registers, dual_chg, optional chg_cnt.
// TESTING (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, SETTLE_CYCLES=3)
//  1 Reset with btn_x1=1 -> all outputs 0; release -> x1=1 and change_pulse at cycle 7 after release.
//  2 btn_x1 high 3 cycles then low -> x1 stays 0, no change_pulse, busy stays 0.
//  3 btn_x2,btn_x1 0->1 same cycle -> x1 rises cycle 7, x2 rises cycle 11, dual_chg=1, busy 8-10.
//  4 Reset asserted during SETTLE of case 3 -> x1=0, dual_chg=0 at once; x2 never rises before re-debounce.
//  5 x1 issued, btn_x1 returns low and stays -> x1 falls after settle, only when debounced low.
//  6 FMIC_CHANGE_CNT_EN, 257 accepted changes -> chg_cnt=1; without macro, chg_cnt absent.

Source files
------------

// File: rtl/fmic_pkg.sv
// rtl/fmic_pkg.sv - shared FSM state type, default parameters and counter width helper for fm_input_conditioner
package fmic_pkg;

  // Presentation FSM: IDLE issues at most one output change, SETTLE holds a quiet gap
  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } fmic_state_e;

  localparam int FMIC_SYNC_STAGES     = 2;
  localparam int FMIC_DEBOUNCE_CYCLES = 1_000_000;
  localparam int FMIC_SETTLE_CYCLES   = 16;
  localparam int FMIC_CHG_CNT_W       = 8;

  // Width of a counter that must hold 0 .. n-1 (terminal count is n-1)
  function automatic int fmic_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fmic_debounce.sv
// rtl/fmic_debounce.sv - multi-flop synchronizer plus consecutive-stable-cycle debouncer for one raw input
module fmic_debounce
  import fmic_pkg::*;
#(
  parameter int SYNC_STAGES     = FMIC_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = FMIC_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam int CW = fmic_cnt_w(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   w_sync;

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign o_level = r_level;

  // Shift the asynchronous input through the synchronizer chain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles;
  // any return to the accepted level restarts the count from zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (w_sync == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      r_level <= w_sync;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fm_input_conditioner.sv
// rtl/fm_input_conditioner.sv - debounced two-input front end issuing one x2/x1 change at a time; FMIC_CHANGE_CNT_EN adds chg_cnt
module fm_input_conditioner
  import fmic_pkg::*;
#(
  parameter int SYNC_STAGES     = FMIC_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = FMIC_DEBOUNCE_CYCLES,
  parameter int SETTLE_CYCLES   = FMIC_SETTLE_CYCLES
) (
  input  logic       sys_clk_in,
  input  logic       sys_rst_n,
  input  logic       btn_x2,
  input  logic       btn_x1,
  output logic       x2,
  output logic       x1,
  output logic       change_pulse,
  output logic       busy,
  output logic       dual_chg
`ifdef FMIC_CHANGE_CNT_EN
  ,
  output logic [FMIC_CHG_CNT_W-1:0] chg_cnt
`endif
);

  localparam int SCW = fmic_cnt_w(SETTLE_CYCLES);

  logic        w_d2;
  logic        w_d1;
  fmic_state_e r_state;
  fmic_state_e w_state_nxt;
  logic [SCW-1:0] r_settle_cnt;
  logic [SCW-1:0] w_settle_nxt;
  logic        r_x2;
  logic        r_x1;
  logic        w_x2_nxt;
  logic        w_x1_nxt;
  logic        r_pulse;
  logic        w_pulse_nxt;
  logic        r_busy;
  logic        r_dual;
  logic        w_dual_set;

  fmic_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_x2 (
    .i_clk  (sys_clk_in),
    .i_rst_n(sys_rst_n),
    .i_raw  (btn_x2),
    .o_level(w_d2)
  );

  fmic_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_x1 (
    .i_clk  (sys_clk_in),
    .i_rst_n(sys_rst_n),
    .i_raw  (btn_x1),
    .o_level(w_d1)
  );

  // Next-state and output decisions; IDLE always looks at the live debounced levels,
  // so a level that reverted during SETTLE is simply no longer a difference
  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle_cnt;
    w_x2_nxt     = r_x2;
    w_x1_nxt     = r_x1;
    w_pulse_nxt  = 1'b0;
    w_dual_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_d1 != r_x1) begin
          // x1 wins a tie; x2 is picked up by a later IDLE cycle if still pending
          w_x1_nxt     = w_d1;
          w_pulse_nxt  = 1'b1;
          w_state_nxt  = SETTLE;
          w_settle_nxt = '0;
          w_dual_set   = (w_d2 != r_x2);
        end else if (w_d2 != r_x2) begin
          w_x2_nxt     = w_d2;
          w_pulse_nxt  = 1'b1;
          w_state_nxt  = SETTLE;
          w_settle_nxt = '0;
        end
      end
      SETTLE: begin
        if (r_settle_cnt == SCW'(SETTLE_CYCLES - 1)) begin
          w_state_nxt  = IDLE;
          w_settle_nxt = '0;
        end else begin
          w_settle_nxt = r_settle_cnt + SCW'(1);
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_settle_nxt = '0;
      end
    endcase
  end

  // FSM state and settle counter
  always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= IDLE;
      r_settle_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
    end
  end

  // Registered outputs; busy trails the state by one cycle so it covers exactly the
  // SETTLE_CYCLES cycles that follow the change cycle
  always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_x2    <= 1'b0;
      r_x1    <= 1'b0;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
      r_dual  <= 1'b0;
    end else begin
      r_x2    <= w_x2_nxt;
      r_x1    <= w_x1_nxt;
      r_pulse <= w_pulse_nxt;
      r_busy  <= (r_state == SETTLE);
      r_dual  <= r_dual | w_dual_set;
    end
  end

  assign x2           = r_x2;
  assign x1           = r_x1;
  assign change_pulse = r_pulse;
  assign busy         = r_busy;
  assign dual_chg     = r_dual;

`ifdef FMIC_CHANGE_CNT_EN
  logic [FMIC_CHG_CNT_W-1:0] r_chg_cnt;

  // Count accepted changes, advancing on the same edge that raises change_pulse; wraps naturally
  always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_chg_cnt <= '0;
    end else if (w_pulse_nxt) begin
      r_chg_cnt <= r_chg_cnt + FMIC_CHG_CNT_W'(1);
    end
  end

  assign chg_cnt = r_chg_cnt;
`endif

endmodule
